// File: rtl/calc_result_display.sv
// Result-bus display back end: captures an 8-bit result, converts it to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit 7-segment display.
module calc_result_display #(
  parameter int SCAN_DIV = 1024,
  parameter int SCAN_W   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  input  logic       signed_mode,
  output logic [6:0] seg_out,
  output logic [3:0] digit_en,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        iter_q, iter_d;
  logic [7:0]        mag_q, mag_d;
  logic [11:0]       bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_val_q, pend_val_d;
  logic              pend_mode_q, pend_mode_d;
  logic [11:0]       disp_bcd_q, disp_bcd_d;
  logic              disp_neg_q, disp_neg_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [11:0]       bcd_adj;

  // Returns {neg, magnitude}; in signed mode 8'h80 maps to a magnitude of 128.
  function automatic logic [8:0] capture(input logic [7:0] v, input logic m);
    if (m && v[7]) capture = {1'b1, (~v) + 8'd1};
    else           capture = {1'b0, v};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
  end

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    pend_mode_d = pend_mode_q;
    disp_bcd_d  = disp_bcd_q;
    disp_neg_d  = disp_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (result_valid) begin
          {neg_d, mag_d} = capture(result_in, signed_mode);
          bcd_d   = 12'd0;
          iter_d  = 3'd0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d  = {bcd_adj[10:0], mag_q[7]};
        mag_d  = {mag_q[6:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        disp_bcd_d = bcd_q;
        disp_neg_d = neg_q;
        if (pend_q) begin
          {neg_d, mag_d} = capture(pend_val_q, pend_mode_q);
          bcd_d   = 12'd0;
          iter_d  = 3'd0;
          state_d = ST_CONVERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pulse arriving in LOAD refills the buffer even while the old entry is consumed.
    if (state_q != ST_IDLE && result_valid) begin
      pend_d      = 1'b1;
      pend_val_d  = result_in;
      pend_mode_d = signed_mode;
    end else if (state_q == ST_LOAD && pend_q) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      iter_q      <= 3'd0;
      mag_q       <= 8'd0;
      bcd_q       <= 12'd0;
      neg_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_val_q  <= 8'd0;
      pend_mode_q <= 1'b0;
      disp_bcd_q  <= 12'd0;
      disp_neg_q  <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      pend_mode_q <= pend_mode_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_neg_q  <= disp_neg_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign digit_en = 4'(4'b0001 << digit_idx_q);

  always_comb begin
    seg_out = 7'h00;
    case (digit_idx_q)
      2'd0: seg_out = seg7(disp_bcd_q[3:0]);
      2'd1: seg_out = (disp_bcd_q[11:8] == 4'd0 && disp_bcd_q[7:4] == 4'd0) ? 7'h00 : seg7(disp_bcd_q[7:4]);
      2'd2: seg_out = (disp_bcd_q[11:8] == 4'd0) ? 7'h00 : seg7(disp_bcd_q[11:8]);
      2'd3: seg_out = disp_neg_q ? 7'h40 : 7'h00;
      default: seg_out = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: random and directed results, decimal reference model,
// scoreboard queue popped by a monitor each time a conversion completes.
module tb_calc_result_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] result_in;
  logic       result_valid;
  logic       signed_mode;
  logic [6:0] seg_out;
  logic [3:0] digit_en;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];

  calc_result_display #(.SCAN_DIV(4), .SCAN_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .result_in(result_in), .result_valid(result_valid),
    .signed_mode(signed_mode), .seg_out(seg_out), .digit_en(digit_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected display as {sign, hundreds, tens, ones} segment codes.
  function automatic logic [27:0] expect_disp(input logic [7:0] v, input logic m);
    int mag;
    logic neg;
    logic [6:0] s0, s1, s2, s3;
    neg = m && v[7];
    mag = neg ? 256 - int'(v) : int'(v);
    s0 = seg_of(mag % 10);
    s1 = (mag >= 10)  ? seg_of((mag / 10) % 10) : 7'h00;
    s2 = (mag >= 100) ? seg_of(mag / 100) : 7'h00;
    s3 = neg ? 7'h40 : 7'h00;
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [6:0] sel_seg(input logic [27:0] e, input logic [3:0] en);
    case (en)
      4'b0001: return e[6:0];
      4'b0010: return e[13:7];
      4'b0100: return e[20:14];
      4'b1000: return e[27:21];
      default: return 7'hxx;
    endcase
  endfunction

  // Monitor: each busy fall means new display contents; sample one full scan.
  initial begin
    logic prev;
    logic bad;
    logic [6:0] got[4];
    logic [27:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev && !busy && rst_n) begin
        bad = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = 7'hxx;
        for (int i = 0; i < 16; i++) begin
          if (i > 0) @(negedge clk);
          if (!$onehot(digit_en)) bad = 1'b1;
          case (digit_en)
            4'b0001: got[0] = seg_out;
            4'b0010: got[1] = seg_out;
            4'b0100: got[2] = seg_out;
            4'b1000: got[3] = seg_out;
            default: bad = 1'b1;
          endcase
        end
        check("digit_en_onehot", 32'(bad), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got display update expected none");
        end else begin
          e = exp_q.pop_front();
          check("ones", 32'(got[0]), 32'(e[6:0]));
          check("tens", 32'(got[1]), 32'(e[13:7]));
          check("hundreds", 32'(got[2]), 32'(e[20:14]));
          check("sign", 32'(got[3]), 32'(e[27:21]));
        end
      end
      prev = busy;
    end
  end

  task automatic send(input logic [7:0] v, input logic m);
    logic bad;
    exp_q.push_back(expect_disp(v, m));
    @(negedge clk);
    result_in = v;
    signed_mode = m;
    result_valid = 1'b1;
    bad = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      result_valid = 1'b0;
      if (n <= 9 && !busy) bad = 1'b1;
      if (n == 10 && busy) bad = 1'b1;
    end
    check("busy_window", 32'(bad), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic burst();
    logic bad_busy, bad12;
    logic [27:0] e12;
    e12 = expect_disp(8'd12, 1'b0);
    exp_q.push_back(expect_disp(8'd200, 1'b0));
    bad_busy = 1'b0;
    bad12 = 1'b0;
    @(negedge clk);
    result_in = 8'd12;
    signed_mode = 1'b0;
    result_valid = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n <= 18 && !busy) bad_busy = 1'b1;
      if (n == 19 && busy) bad_busy = 1'b1;
      if (n >= 10 && n <= 18 && seg_out !== sel_seg(e12, digit_en)) bad12 = 1'b1;
      if (n == 1) result_in = 8'd99;
      if (n == 2) result_in = 8'd200;
      if (n == 3) result_valid = 1'b0;
    end
    check("burst_busy", 32'(bad_busy), 32'd0);
    check("burst_shows_12", 32'(bad12), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic reset_mid_convert();
    @(negedge clk);
    result_in = 8'd255;
    signed_mode = 1'b0;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digit_en", 32'(digit_en), 32'h1);
    check("async_rst_seg", 32'(seg_out), 32'h3F);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'd7, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    result_in = 8'd0;
    result_valid = 1'b0;
    signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_digit_en", 32'(digit_en), 32'h1);
    check("rst_seg", 32'(seg_out), 32'h3F);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check("scan_digit_en", 32'(digit_en), 32'(4'b0001 << ((k / 4) % 4)));
      check("scan_seg", 32'(seg_out), ((k / 4) % 4 == 0) ? 32'h3F : 32'h00);
    end
    send(8'd237, 1'b0);
    send(8'hFB, 1'b1);
    send(8'hFB, 1'b0);
    send(8'h80, 1'b1);
    send(8'd0, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    send(8'd9, 1'b0);
    send(8'd10, 1'b0);
    send(8'd100, 1'b0);
    for (int r = 0; r < 16; r++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    burst();
    reset_mid_convert();
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
